// File: rtl/vga_tile_scanout_if.sv
// Video-memory read port between the scanout engine (master) and the tile memory (slave).
interface vga_tile_scanout_if;
  logic [9:0] oReadAddress;
  logic [2:0] iReadData;

  modport master (output oReadAddress, input iReadData);
  modport slave  (input oReadAddress, output iReadData);
endinterface

// File: rtl/vga_tile_scanout.sv
// VGA timing generator and tiled-memory scanout: 32x16-pixel tiles, 3-bit colour,
// with sync/blank delayed to line up with the memory read latency.
module vga_tile_scanout #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        iEnable,
  vga_tile_scanout_if.master          memBus,
  output logic                        oHorizontalSync,
  output logic                        oVerticalSync,
  output logic                        oRed,
  output logic                        oGreen,
  output logic                        oBlue,
  output logic [9:0]                  oColumnCount,
  output logic [9:0]                  oRowCount,
  output logic                        oVBlank,
  output logic                        oFrameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned PIPE    = 1 + RD_LATENCY;

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0]       V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0]       HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]       VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] divCnt;
  logic [9:0]       col;
  logic [9:0]       row;
  logic             tick;
  logic             colLast;
  logic             rowLast;
  logic             hsNow;
  logic             vsNow;
  logic             actNow;
  logic [PIPE-1:0]  hsPipe;
  logic [PIPE-1:0]  vsPipe;
  logic [PIPE-1:0]  actPipe;

  always_comb begin
    tick    = iEnable && (divCnt == DIV_LAST);
    colLast = (col == H_LAST);
    rowLast = (row == V_LAST);
    hsNow   = (col >= HS_FIRST) && (col <= HS_LAST);
    vsNow   = (row >= VS_FIRST) && (row <= VS_LAST);
    actNow  = (col < H_VIS) && (row < V_VIS);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      divCnt      <= '0;
      col         <= '0;
      row         <= '0;
      oFrameStart <= 1'b0;
    end else begin
      oFrameStart <= tick && colLast && rowLast;
      if (iEnable) begin
        divCnt <= tick ? '0 : divCnt + DIV_W'(1);
      end
      if (tick) begin
        if (colLast) begin
          col <= '0;
          row <= rowLast ? '0 : row + 10'd1;
        end else begin
          col <= col + 10'd1;
        end
      end
    end
  end

  // Pipelines hold sync as active-high so every stage clears to 0 yet the pins reset high.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      memBus.oReadAddress <= '0;
      hsPipe              <= '0;
      vsPipe              <= '0;
      actPipe             <= '0;
    end else begin
      memBus.oReadAddress <= {row[8:4], col[9:5]};
      hsPipe              <= {hsPipe[PIPE-2:0], hsNow};
      vsPipe              <= {vsPipe[PIPE-2:0], vsNow};
      actPipe             <= {actPipe[PIPE-2:0], actNow};
    end
  end

  always_comb begin
    oHorizontalSync          = ~hsPipe[PIPE-1];
    oVerticalSync            = ~vsPipe[PIPE-1];
    {oRed, oGreen, oBlue}    = actPipe[PIPE-1] ? memBus.iReadData : 3'b000;
    oColumnCount             = col;
    oRowCount                = row;
    oVBlank                  = (row >= V_VIS);
  end

endmodule

// File: tb/tb_vga_tile_scanout.sv
// Directed bench: a full-size instance for line timing and a shrunken-frame instance
// for tile colour, blanking, vsync, frame-start, enable freeze and async reset.
module tb_vga_tile_scanout;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic enD   = 1'b1;
  logic enS   = 1'b1;
  logic memMode = 1'b0;

  always #5 Clock = ~Clock;

  // Full-size instance
  vga_tile_scanout_if dIf ();
  logic       dHs, dVs, dR, dG, dB, dVb, dFs;
  logic [9:0] dCol, dRow;
  assign dIf.iReadData = 3'b000;

  vga_tile_scanout dutD (
    .Clock(Clock), .Reset(Reset), .iEnable(enD), .memBus(dIf),
    .oHorizontalSync(dHs), .oVerticalSync(dVs),
    .oRed(dR), .oGreen(dG), .oBlue(dB),
    .oColumnCount(dCol), .oRowCount(dRow), .oVBlank(dVb), .oFrameStart(dFs)
  );

  // Small-frame instance: 104 x 45 total, 80 x 36 visible
  // hsync cols 86..95, vsync rows 39..40
  vga_tile_scanout_if sIf ();
  logic       sHs, sVs, sR, sG, sB, sVb, sFs;
  logic [9:0] sCol, sRow;

  vga_tile_scanout #(
    .H_VISIBLE(80), .H_FRONT(6), .H_SYNC(10), .H_BACK(8),
    .V_VISIBLE(36), .V_FRONT(3), .V_SYNC(2),  .V_BACK(4),
    .PIX_DIV(2), .RD_LATENCY(1)
  ) dutS (
    .Clock(Clock), .Reset(Reset), .iEnable(enS), .memBus(sIf),
    .oHorizontalSync(sHs), .oVerticalSync(sVs),
    .oRed(sR), .oGreen(sG), .oBlue(sB),
    .oColumnCount(sCol), .oRowCount(sRow), .oVBlank(sVb), .oFrameStart(sFs)
  );

  // One-cycle-latency tile memory
  always @(posedge Clock)
    sIf.iReadData <= memMode ? 3'b111 : ((sIf.oReadAddress == 10'd33) ? 3'b101 : 3'b000);

  int fsCount = 0;
  always @(negedge Clock) if (sFs === 1'b1) fsCount++;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Advance to 1 time unit after edge number e counted from reset release.
  task automatic gotoE(input int e);
    clk(e - cur);
    cur = e;
  endtask

  initial begin
    // Reset values
    clk(3);
    check("rst_scol", sCol, 0);
    check("rst_srow", sRow, 0);
    check("rst_saddr", sIf.oReadAddress, 0);
    check("rst_shs", sHs, 1);
    check("rst_svs", sVs, 1);
    check("rst_srgb", {sR, sG, sB}, 0);
    check("rst_svb", sVb, 0);
    check("rst_sfs", sFs, 0);

    @(negedge Clock);
    Reset = 1'b1;
    cur = 0;

    // Pixel tick after PIX_DIV clocks
    gotoE(1);
    check("d_col_e1", dCol, 0);
    check("s_col_e1", sCol, 0);
    gotoE(2);
    check("d_col_e2", dCol, 1);
    check("s_col_e2", sCol, 1);
    check("s_fs_release", fsCount, 0);

    // Full-size hsync: counters reach 656 at edge 1312, pin low edges 1314..1505
    gotoE(1313);
    check("d_col_656", dCol, 656);
    check("d_hs_before", dHs, 1);
    gotoE(1314);
    check("d_hs_fall", dHs, 0);
    gotoE(1505);
    check("d_hs_last", dHs, 0);
    gotoE(1506);
    check("d_hs_rise", dHs, 1);
    gotoE(1599);
    check("d_col_799", dCol, 799);
    check("d_row_0", dRow, 0);
    gotoE(1600);
    check("d_col_wrap", dCol, 0);
    check("d_row_1", dRow, 1);

    // Tile colour: address 33 covers cols 32..63 of rows 16..31
    gotoE(3202);
    check("rgb_40_15", {sR, sG, sB}, 3'b000);
    gotoE(3392);
    check("rgb_31_16", {sR, sG, sB}, 3'b000);
    gotoE(3394);
    check("rgb_32_16", {sR, sG, sB}, 3'b101);
    gotoE(6576);
    check("rgb_63_31", {sR, sG, sB}, 3'b101);
    gotoE(6578);
    check("rgb_64_31", {sR, sG, sB}, 3'b000);
    gotoE(6784);
    check("rgb_63_32", {sR, sG, sB}, 3'b000);

    // Memory returns 7 everywhere: blanking must force 0
    memMode = 1'b1;
    gotoE(7440);
    check("rgb_79_35", {sR, sG, sB}, 3'b111);
    gotoE(7442);
    check("rgb_80_35", {sR, sG, sB}, 3'b000);
    gotoE(7486);
    check("vb_103_35", sVb, 0);
    gotoE(7488);
    check("vb_0_36", sVb, 1);
    check("row_36", sRow, 36);
    gotoE(7490);
    check("rgb_0_36", {sR, sG, sB}, 3'b000);

    // Vsync rows 39..40, delayed two clocks
    gotoE(8112);
    check("vs_103_38", sVs, 1);
    gotoE(8114);
    check("vs_0_39", sVs, 0);
    gotoE(8528);
    check("vs_103_40", sVs, 0);
    gotoE(8530);
    check("vs_0_41", sVs, 1);

    // Frame wrap at tick 4680 -> edge 9360
    gotoE(9359);
    check("pre_wrap_col", sCol, 103);
    check("pre_wrap_row", sRow, 44);
    check("pre_wrap_fs", sFs, 0);
    gotoE(9360);
    check("wrap_fs", sFs, 1);
    check("wrap_col", sCol, 0);
    check("wrap_row", sRow, 0);
    gotoE(9361);
    check("wrap_fs_clear", sFs, 0);
    check("fs_count_1", fsCount, 1);

    // Enable freeze at column 100
    gotoE(9560);
    check("freeze_col_start", sCol, 100);
    enS = 1'b0;
    clk(50);
    check("freeze_col_hold", sCol, 100);
    check("freeze_row_hold", sRow, 0);
    enS = 1'b1;
    gotoE(9561);
    check("resume_col_e1", sCol, 100);
    gotoE(9562);
    check("resume_col_e2", sCol, 101);
    check("fs_count_freeze", fsCount, 1);

    // Asynchronous reset mid-frame at (50,20)
    gotoE(13620);
    check("pre_rst_col", sCol, 50);
    check("pre_rst_row", sRow, 20);
    check("pre_rst_rgb", {sR, sG, sB}, 3'b111);
    #2;
    Reset = 1'b0;
    #1;
    check("arst_col", sCol, 0);
    check("arst_row", sRow, 0);
    check("arst_addr", sIf.oReadAddress, 0);
    check("arst_rgb", {sR, sG, sB}, 3'b000);
    check("arst_hs", sHs, 1);
    check("arst_vs", sVs, 1);
    check("arst_dcol", dCol, 0);

    @(negedge Clock);
    Reset = 1'b1;
    clk(1);
    check("rel_col_e1", sCol, 0);
    clk(1);
    check("rel_col_e2", sCol, 1);
    check("rel_row_e2", sRow, 0);
    check("rel_fs", sFs, 0);
    check("fs_count_final", fsCount, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
